// File: rtl/inverse_factorial_if.sv
// inverse_factorial_if: start/done request interface of the inverse-factorial unit.
//   start  - request pulse from the master; taken only while busy is low
//   value  - operand that goes with start
//   busy   - computation in progress
//   done   - one-cycle pulse; n/exact are valid in the same cycle
//   n      - largest n with n! <= value
//   exact  - value == n!
// Handshake: the unit accepts a request on a rising edge where start=1 and
// busy=0, which includes the cycle where done is high. The result arrives
// later as a single-cycle done pulse. A start seen while busy=1 is dropped.
// The unit never applies back-pressure.
interface inverse_factorial_if #(
    parameter int N_WIDTH  = 8,
    parameter int FN_WIDTH = 32
);
    logic                start;
    logic [FN_WIDTH-1:0] value;
    logic                busy;
    logic                done;
    logic [N_WIDTH-1:0]  n;
    logic                exact;

    modport master (output start, value, input busy, done, n, exact);
    modport slave  (input start, value, output busy, done, n, exact);
endinterface

// File: rtl/inverse_factorial.sv
// inverse_factorial: iterative inverse factorial with one multiply per clock.
// Finds the largest n with n! <= value and reports whether value == n!.
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous, active-high reset; aborts a running computation
//   bus       - inverse_factorial_if.slave (start/value in, busy/done/n/exact out)
//   dbg_state - current FSM state (0=IDLE, 1=CALC, 2=DONE)
// Timing: the result is picked in CALC. It is published one edge later, as the
// FSM leaves DONE. So done is high max(n,1)+1 cycles after the accepting edge.
// The done cycle is an IDLE cycle, so a new start in that cycle is taken with
// no gap between requests.
module inverse_factorial #(
    parameter int N_WIDTH  = 8,
    parameter int FN_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    inverse_factorial_if.slave  bus,
    output logic [1:0]          dbg_state
);
    // The product is one bit wider than FN_WIDTH+N_WIDTH. That extra bit means
    // (k+1) = 2^N_WIDTH in the iteration-cap case still multiplies without wrap.
    localparam int PW = FN_WIDTH + N_WIDTH + 1;
    localparam logic [N_WIDTH-1:0] K_MAX = '1;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t              state;
    logic [FN_WIDTH-1:0] val_q;
    logic [FN_WIDTH-1:0] acc;
    logic [N_WIDTH-1:0]  k;
    logic [N_WIDTH-1:0]  res_n;
    logic                res_exact;
    logic                busy;
    logic                done;
    logic [N_WIDTH-1:0]  n;
    logic                exact;

    logic [N_WIDTH:0]    k_next;
    logic [PW-1:0]       prod;
    logic [PW-1:0]       val_ext;

    assign k_next  = {1'b0, k} + {{N_WIDTH{1'b0}}, 1'b1};
    assign prod    = {{(N_WIDTH + 1){1'b0}}, acc} * {{FN_WIDTH{1'b0}}, k_next};
    assign val_ext = {{(N_WIDTH + 1){1'b0}}, val_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            val_q     <= '0;
            acc       <= '0;
            k         <= '0;
            res_n     <= '0;
            res_exact <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            n         <= '0;
            exact     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        val_q <= bus.value;
                        acc   <= FN_WIDTH'(1);
                        k     <= N_WIDTH'(1);
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (val_q == '0) begin
                        res_n     <= '0;
                        res_exact <= 1'b0;
                        state     <= DONE;
                    end else if (prod > val_ext || k == K_MAX) begin
                        // acc = k! <= val_q here; the next factorial overshoots
                        // or the count has reached its cap.
                        res_n     <= k;
                        res_exact <= (acc == val_q);
                        state     <= DONE;
                    end else begin
                        // prod <= val_q, so this narrowing loses nothing.
                        acc <= prod[FN_WIDTH-1:0];
                        k   <= k_next[N_WIDTH-1:0];
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    n     <= res_n;
                    exact <= res_exact;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = busy;
    assign bus.done  = done;
    assign bus.n     = n;
    assign bus.exact = exact;
    assign dbg_state = state;
endmodule

// File: tb/tb_inverse_factorial.sv
module tb_inverse_factorial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [8:0] exp_q[$];   // {exact, n[7:0]}
    int         lat_q[$];   // cycle count at which done must be visible

    logic [1:0] dbg_state;
    logic [1:0] dbg_state_s;

    inverse_factorial_if #(.N_WIDTH(8), .FN_WIDTH(32)) bus ();
    inverse_factorial_if #(.N_WIDTH(2), .FN_WIDTH(32)) bus_s ();

    inverse_factorial #(.N_WIDTH(8), .FN_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
    );
    inverse_factorial #(.N_WIDTH(2), .FN_WIDTH(32)) dut_s (
        .clk(clk), .rst(rst), .bus(bus_s), .dbg_state(dbg_state_s)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] fact(input int k);
        logic [63:0] f;
        f = 64'd1;
        for (int i = 2; i <= k; i++) f = f * 64'(i);
        return f;
    endfunction

    // Reference: walk factorials upward until the next one exceeds v.
    function automatic logic [8:0] ref_inv(input logic [31:0] v);
        logic [63:0] f;
        int          k;
        if (v == 32'd0) return 9'd0;
        f = 64'd1;
        k = 1;
        while (f * 64'(k + 1) <= 64'(v)) begin
            k++;
            f = f * 64'(k);
        end
        return {f == 64'(v), 8'(k)};
    endfunction

    // driver: call at a negedge; drives start for one cycle and records expectations
    task automatic issue(input logic [31:0] v, input int en, input bit ex);
        logic [7:0] en8;
        en8 = 8'(en);
        bus.value = v;
        bus.start = 1'b1;
        exp_q.push_back({ex, en8});
        lat_q.push_back(cyc + 1 + ((en > 1) ? en : 1) + 1);
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1);
    endtask

    task automatic run_op(input logic [31:0] v, input int en, input bit ex);
        @(negedge clk);
        issue(v, en, ex);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() > 0) begin
            check("timeout", exp_q.size(), 0);
            exp_q.delete();
            lat_q.delete();
        end
        @(negedge clk);
    endtask

    // scoreboard: compare each done pulse against the oldest expectation
    always @(posedge clk) begin
        #1;
        if (!rst && bus.done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                logic [8:0] e;
                int         l;
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                check("n", bus.n, e[7:0]);
                check("exact", bus.exact, e[8]);
                check("latency", cyc, l);
                check("busy_at_done", bus.busy, 0);
            end
        end
    end

    initial begin
        logic [31:0] rv;
        logic [8:0]  rr;
        int          t;
        bus.start   = 1'b0;
        bus.value   = '0;
        bus_s.start = 1'b0;
        bus_s.value = '0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_n", bus.n, 0);
        check("rst_exact", bus.exact, 0);
        check("rst_state", dbg_state, 0);

        // main function and boundaries
        run_op(32'd3628800, 10, 1'b1);
        wait_idle();
        check("busy_after_done", bus.busy, 0);
        check("n_held", bus.n, 10);
        run_op(32'd3628801, 10, 1'b0);    wait_idle();
        run_op(32'd3628799, 9, 1'b0);     wait_idle();
        run_op(32'd0, 0, 1'b0);           wait_idle();
        run_op(32'd1, 1, 1'b1);           wait_idle();
        run_op(32'd2, 2, 1'b1);           wait_idle();
        run_op(32'hFFFFFFFF, 12, 1'b0);   wait_idle();
        run_op(32'd479001600, 12, 1'b1);  wait_idle();

        // start while busy is ignored; start in the done cycle is accepted
        run_op(32'd120, 5, 1'b1);
        @(negedge clk);
        bus.value = 32'd6;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        t = 0;
        while (!bus.done && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("done_seen_b2b", bus.done, 1);
        issue(32'd24, 4, 1'b1);
        wait_idle();

        // reset abort during the 4th CALC cycle
        @(negedge clk);
        bus.value = 32'd3628800;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("abort_state_calc", dbg_state, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_n", bus.n, 0);
        check("abort_exact", bus.exact, 0);
        repeat (15) @(negedge clk);
        run_op(32'd720, 6, 1'b1);
        wait_idle();

        // round trip from factorials
        for (int k = 0; k <= 12; k++) begin
            run_op(32'(fact(k)), (k > 1) ? k : 1, 1'b1);
            wait_idle();
        end

        // random operands against the reference
        for (int i = 0; i < 8; i++) begin
            rv = (i < 4) ? 32'($urandom_range(0, 5000)) : $urandom;
            rr = ref_inv(rv);
            run_op(rv, int'(rr[7:0]), rr[8]);
            wait_idle();
        end

        // iteration cap on a 2-bit result
        @(negedge clk);
        bus_s.value = 32'd1000;
        bus_s.start = 1'b1;
        @(negedge clk);
        bus_s.start = 1'b0;
        t = 0;
        while (!bus_s.done && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("cap_done", bus_s.done, 1);
        check("cap_n", bus_s.n, 3);
        check("cap_exact", bus_s.exact, 0);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
